line_mem_responder: RTL and testbench



---
 rtl/line_mem_responder.sv | 92 +++++++++
 tb/tb_line_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency 128-bit line memory; define LINE_MEM_PROTO_CHECK_EN for the sticky proto_err checker.
module line_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY > 1 ? LATENCY - 2 : 0);
    state_t                state;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  op;
    logic [127:0]          wdata_q;
    logic [127:0]          storage [2**DEPTH_LOG2];
    logic                  start, held, mem_we;
    logic                  unused_addr;
    assign unused_addr = ^mem_addr;
    always_comb begin
        start  = (state == IDLE) && (mem_read ^ mem_write);
        held   = op ? mem_write : mem_read;
        // a single-cycle latency commits the write on leaving RESP, so a request seen during reset never lands
        mem_we = op && ((LATENCY == 1) ? state == RESP : (state == WAIT && held && cnt == 8'd0));
    end
    always_ff @(posedge clk)
        if (mem_we) storage[idx] <= wdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            idx       <= '0;
            op        <= 1'b0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    idx     <= mem_addr[DEPTH_LOG2-1:0];
                    op      <= mem_write;
                    wdata_q <= mem_wdata;
                    cnt     <= CNT_INIT;
                    if (LATENCY == 1) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        if (!mem_write) mem_rdata <= storage[mem_addr[DEPTH_LOG2-1:0]];
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (!held) begin
                    state <= IDLE;
                end else if (cnt == 8'd0) begin
                    state     <= RESP;
                    mem_ready <= 1'b1;
                    if (!op) mem_rdata <= storage[idx];
                end else begin
                    cnt <= cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef LINE_MEM_PROTO_CHECK_EN
    logic [27:0] addr_q;
    logic        viol;
    always_comb viol = (mem_read && mem_write) || (state == WAIT && (mem_addr != addr_q || !held));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            addr_q    <= '0;
        end else begin
            if (start) addr_q <= mem_addr;
            if (viol) begin
                proto_err <= 1'b1;
                $display("line_mem_responder: protocol violation at time %0t", $time);
            end
        end
    end
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: random scoreboard bench for the LATENCY=4 responder plus directed LATENCY=1 checks.
module tb_line_mem_responder;
    localparam int LAT = 4;
`ifdef LINE_MEM_PROTO_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif
    typedef struct {int due; bit wr; logic [127:0] data;} exp_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0, mem_rdata;
    logic         mem_ready, proto_err;
    logic         r1 = 1'b0, w1 = 1'b0;
    logic [27:0]  a1 = '0;
    logic [127:0] d1 = '0, rd1;
    logic         rdy1, pe1;

    int           cyc = 0, total = 0, bad = 0;
    exp_t         sbq[$];
    logic [127:0] mdl [int];
    logic [127:0] exp_last = '0;
    bit           exp_perr = 1'b0, mon_en = 1'b0, prev_rdy = 1'b0;

    line_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u0 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .proto_err(proto_err));
    line_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .mem_read(r1), .mem_write(w1), .mem_addr(a1),
        .mem_wdata(d1), .mem_rdata(rd1), .mem_ready(rdy1), .proto_err(pe1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, want);
        end
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops one expectation per mem_ready pulse; checks hold/proto_err every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("proto_err", 128'(proto_err), 128'(exp_perr));
            if (mem_ready) begin
                chk("ready_one_cycle", 128'(prev_rdy), 128'(0));
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready @cycle %0d: got mem_ready=1 want no pending request", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("ready_cycle", 128'(cyc), 128'(e.due));
                    if (!e.wr) exp_last = e.data;
                    chk(e.wr ? "wr_rdata_hold" : "rd_data", mem_rdata, exp_last);
                end
            end else begin
                chk("rdata_hold", mem_rdata, exp_last);
            end
            prev_rdy = mem_ready;
        end
    end

    // Issue one held request at a negedge; returns one cycle after mem_ready with requests dropped.
    task automatic txn(input bit wr, input logic [27:0] a, input logic [127:0] d);
        int k;
        k = int'(a[7:0]);
        mem_addr  = a;
        mem_read  = !wr;
        mem_write = wr;
        mem_wdata = d;
        sbq.push_back('{cyc + LAT, wr, wr ? 128'(0) : mdl[k]});
        if (wr) mdl[k] = d;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (mem_ready) break;
            if (wr) mem_wdata = rnd128();
        end
        if (!mem_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout @cycle %0d: got no mem_ready want one within %0d cycles", cyc, LAT);
            void'(sbq.pop_back());
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [27:0] alias_addr(input int k);
        return {20'($urandom), 8'(k)};
    endfunction

    initial begin
        logic [127:0] x1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_rdata", mem_rdata, 128'(0));
        chk("rst_proto", 128'(proto_err), 128'(0));
        chk("rst_ready_l1", 128'(rdy1), 128'(0));
        chk("rst_rdata_l1", rd1, 128'(0));
        mon_en = 1'b1;
        // directed: write then immediate read, write then aliased read
        txn(1'b1, 28'h0000003, {4{32'hA5A5A5A5}});
        txn(1'b0, 28'h0000003, 128'(0));
        txn(1'b1, 28'h0000007, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        txn(1'b0, 28'h0000107, 128'(0));
        for (int k = 0; k < 16; k++) txn(1'b1, alias_addr(k), rnd128());
        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom_range(0, 1)), alias_addr(int'($urandom_range(0, 15))), rnd128());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        // abort: write dropped in the last WAIT cycle must not land
        mem_addr  = alias_addr(5);
        mem_wdata = rnd128();
        mem_write = 1'b1;
        repeat (3) @(negedge clk);
        mem_write = 1'b0;
        @(posedge clk);
        #1 exp_perr = PCHK;
        repeat (2) @(negedge clk);
        txn(1'b0, alias_addr(5), 128'(0));
        // async reset mid-WAIT of a write
        txn(1'b0, alias_addr(9), 128'(0));
        mem_addr  = alias_addr(9);
        mem_wdata = rnd128();
        mem_write = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        mem_write = 1'b0;
        exp_last  = '0;
        exp_perr  = 1'b0;
        #1;
        chk("async_rst_ready", 128'(mem_ready), 128'(0));
        chk("async_rst_rdata", mem_rdata, 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, alias_addr(9), 128'(0));
        // both requests high: never serviced
        mem_addr  = alias_addr(4);
        mem_read  = 1'b1;
        mem_write = 1'b1;
        @(posedge clk);
        #1 exp_perr = PCHK;
        repeat (6) @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        txn(1'b0, alias_addr(4), 128'(0));
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        // LATENCY=1 instance: write, then read held across two transactions
        x1 = rnd128();
        w1 = 1'b1;
        a1 = 28'h0ABCD02;
        d1 = x1;
        @(negedge clk);
        chk("l1_wr_ready", 128'(rdy1), 128'(1));
        w1 = 1'b0;
        d1 = ~x1;
        @(negedge clk);
        chk("l1_wr_ready_drop", 128'(rdy1), 128'(0));
        r1 = 1'b1;
        a1 = 28'h0000102;
        @(negedge clk);
        chk("l1_rd1_ready", 128'(rdy1), 128'(1));
        chk("l1_rd1_data", rd1, x1);
        @(negedge clk);
        chk("l1_gap", 128'(rdy1), 128'(0));
        @(negedge clk);
        chk("l1_rd2_ready", 128'(rdy1), 128'(1));
        chk("l1_rd2_data", rd1, x1);
        @(negedge clk);
        chk("l1_rd2_drop", 128'(rdy1), 128'(0));
        chk("l1_proto_clean", 128'(pe1), 128'(0));
        w1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("l1_both_never", 128'(rdy1), 128'(0));
        end
        r1 = 1'b0;
        w1 = 1'b0;
        @(negedge clk);
        chk("l1_both_proto", 128'(pe1), 128'(PCHK));
        chk("l1_rdata_kept", rd1, x1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t want finish", $time);
        $fatal(1);
    end
endmodule
